// File: rtl/even_parity_generator_reg.sv
// Registered even/odd parity generator with per-lane parity, a running frame parity
// accumulator and a parity checker with a saturating error counter. One cycle of latency.
module even_parity_generator_reg #(
   parameter  int WIDTH  = 3,
   parameter  int LANE_W = WIDTH,
   parameter  int CNT_W  = 8,
   localparam int LANES  = WIDTH / LANE_W
) (
   input  logic             clk,
   input  logic             rst,
   // in_valid qualifies every input word; there is no ready, so each valid
   // word is accepted and its result appears exactly one cycle later.
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in,
   input  logic             odd_sel,
   input  logic             frame_start,
   input  logic             chk_en,
   input  logic [LANES-1:0] chk_parity,
   input  logic             err_clr,
   output logic             out_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             parity,
   output logic [LANES-1:0] lane_parity,
   output logic             frame_parity,
   output logic             chk_err,
   output logic [CNT_W-1:0] err_count
);

   logic             word_par;
   logic [LANES-1:0] lane_raw;
   logic [LANES-1:0] lane_next;
   logic             acc;
   logic             acc_next;
   logic             mismatch;
   logic             cnt_sat;

   always_comb begin
      word_par = ^in;
      lane_raw = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_raw[k] = ^in[k*LANE_W +: LANE_W];
      end
      lane_next = lane_raw ^ {LANES{odd_sel}};
      // acc is kept in even sense so odd_sel can change per word.
      acc_next  = frame_start ? word_par : (acc ^ word_par);
      mismatch  = chk_en && (chk_parity != lane_next);
      cnt_sat   = &err_count;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         data_out     <= '0;
         parity       <= 1'b0;
         lane_parity  <= '0;
         frame_parity <= 1'b0;
         acc          <= 1'b0;
         chk_err      <= 1'b0;
         err_count    <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            data_out     <= in;
            parity       <= word_par ^ odd_sel;
            lane_parity  <= lane_next;
            acc          <= acc_next;
            frame_parity <= acc_next ^ odd_sel;
         end
         // A clear wins over a same-cycle mismatch; that word's error is dropped.
         if (err_clr) begin
            chk_err   <= 1'b0;
            err_count <= '0;
         end else if (in_valid) begin
            chk_err <= mismatch;
            if (mismatch && !cnt_sat) begin
               err_count <= err_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_even_parity_generator_reg.sv
// Randomized and directed bench for even_parity_generator_reg against a ones-counting model.
module tb_even_parity_generator_reg;
   localparam int WIDTH  = 3;
   localparam int LANE_W = 3;
   localparam int CNT_W  = 8;
   localparam int LANES  = WIDTH / LANE_W;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in;
   logic             odd_sel;
   logic             frame_start;
   logic             chk_en;
   logic [LANES-1:0] chk_parity;
   logic             err_clr;
   logic             out_valid;
   logic [WIDTH-1:0] data_out;
   logic             parity;
   logic [LANES-1:0] lane_parity;
   logic             frame_parity;
   logic             chk_err;
   logic [CNT_W-1:0] err_count;

   int errors = 0;
   int checks = 0;

   even_parity_generator_reg #(.WIDTH(WIDTH), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .odd_sel(odd_sel),
      .frame_start(frame_start), .chk_en(chk_en), .chk_parity(chk_parity),
      .err_clr(err_clr), .out_valid(out_valid), .data_out(data_out), .parity(parity),
      .lane_parity(lane_parity), .frame_parity(frame_parity), .chk_err(chk_err),
      .err_count(err_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic logic par_of(input logic [WIDTH-1:0] v);
      return logic'($countones(v) % 2);
   endfunction

   function automatic logic [LANES-1:0] lanes_of(input logic [WIDTH-1:0] v, input logic o);
      logic [LANES-1:0] r;
      logic [WIDTH-1:0] m;
      r = '0;
      m = WIDTH'((1 << LANE_W) - 1);
      for (int k = 0; k < LANES; k++) r[k] = par_of((v >> (k * LANE_W)) & m) ^ o;
      return r;
   endfunction

   logic             exp_valid;
   logic [WIDTH-1:0] exp_data;
   logic             exp_par;
   logic [LANES-1:0] exp_lanes;
   logic             exp_acc;
   logic             exp_fp;
   logic             exp_chk;
   int               exp_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_valid <= 1'b0; exp_data <= '0; exp_par <= 1'b0; exp_lanes <= '0;
         exp_acc <= 1'b0; exp_fp <= 1'b0; exp_chk <= 1'b0; exp_cnt <= 0;
      end else begin
         exp_valid <= in_valid;
         if (in_valid) begin
            exp_data  <= in;
            exp_par   <= par_of(in) ^ odd_sel;
            exp_lanes <= lanes_of(in, odd_sel);
            exp_acc   <= frame_start ? par_of(in) : (exp_acc ^ par_of(in));
            exp_fp    <= (frame_start ? par_of(in) : (exp_acc ^ par_of(in))) ^ odd_sel;
         end
         if (err_clr) begin
            exp_chk <= 1'b0;
            exp_cnt <= 0;
         end else if (in_valid) begin
            exp_chk <= chk_en && (chk_parity != lanes_of(in, odd_sel));
            if (chk_en && (chk_parity != lanes_of(in, odd_sel)) && exp_cnt < CMAX)
               exp_cnt <= exp_cnt + 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", 32'(out_valid), 32'(exp_valid));
         chk("data_out", 32'(data_out), 32'(exp_data));
         chk("parity", 32'(parity), 32'(exp_par));
         chk("lane_parity", 32'(lane_parity), 32'(exp_lanes));
         chk("frame_parity", 32'(frame_parity), 32'(exp_fp));
         chk("chk_err", 32'(chk_err), 32'(exp_chk));
         chk("err_count", 32'(err_count), 32'(exp_cnt));
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic o, input logic fs,
                        input logic ce, input logic [LANES-1:0] cp, input logic ec);
      in_valid = v; in = d; odd_sel = o; frame_start = fs;
      chk_en = ce; chk_parity = cp; err_clr = ec;
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_data_out"}, 32'(data_out), 32'd0);
      chk({tag, "_parity"}, 32'(parity), 32'd0);
      chk({tag, "_frame_parity"}, 32'(frame_parity), 32'd0);
      chk({tag, "_chk_err"}, 32'(chk_err), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   logic [7:0] even_tab;
   logic [7:0] odd_tab;

   initial begin
      even_tab = 8'b1001_0110;
      odd_tab  = 8'b0110_1001;
      rst = 1'b0;
      in_valid = 1'b0; in = '0; odd_sel = 1'b0; frame_start = 1'b0;
      chk_en = 1'b0; chk_parity = '0; err_clr = 1'b0;
      #1 rst = 1'b1;
      #1 check_zero("por");
      @(negedge clk);
      rst = 1'b0;

      // exhaustive even sweep, then odd sweep, back to back
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
         chk("even_sweep_parity", 32'(parity), 32'(even_tab[i]));
         chk("even_sweep_data", 32'(data_out), 32'(i));
         chk("even_sweep_valid", 32'(out_valid), 32'd1);
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0, '0, 1'b0);
         chk("odd_sweep_parity", 32'(parity), 32'(odd_tab[i]));
      end

      // frame accumulator
      drive(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      chk("frame_001", 32'(frame_parity), 32'd1);
      drive(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("frame_011", 32'(frame_parity), 32'd1);
      drive(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      chk("frame_111", 32'(frame_parity), 32'd0);
      drive(1'b1, 3'b000, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      chk("frame_restart", 32'(frame_parity), 32'd0);

      // checker
      drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("chk_mismatch_err", 32'(chk_err), 32'd1);
      chk("chk_mismatch_cnt", 32'(err_count), 32'd1);
      drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("chk_match_err", 32'(chk_err), 32'd0);
      chk("chk_match_cnt", 32'(err_count), 32'd1);
      drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("chk_clr_err", 32'(chk_err), 32'd0);
      chk("chk_clr_cnt", 32'(err_count), 32'd0);

      // saturation
      for (int i = 0; i < (1 << CNT_W) + 3; i++)
         drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("sat_cnt", 32'(err_count), 32'(CMAX));
      chk("sat_err", 32'(chk_err), 32'd1);

      // idle gaps hold outputs
      drive(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_data", 32'(data_out), 32'd4);
         chk("idle_parity", 32'(parity), 32'd1);
         chk("idle_cnt", 32'(err_count), 32'(CMAX));
      end

      // reset mid-stream with 111 in flight
      in_valid = 1'b1; in = 3'b111; odd_sel = 1'b0; chk_en = 1'b0;
      @(posedge clk);
      #1 chk("pre_rst_data", 32'(data_out), 32'd7);
      rst = 1'b1;
      #1 check_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 3'b010, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      chk("post_rst_data", 32'(data_out), 32'd2);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_parity", 32'(parity), 32'd1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(logic'($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
               logic'($urandom_range(0, 1)), logic'($urandom_range(0, 4) == 0),
               logic'($urandom_range(0, 1)), LANES'($urandom_range(0, (1 << LANES) - 1)),
               logic'($urandom_range(0, 15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/even_parity_generator_reg.md
Name: even_parity_generator_reg

Overview:
Registered, parameterised even-parity generator with an optional parity checker and a frame-level running parity accumulator. The combinational core is the classic 3-bit even parity function: parity = XOR of all data bits, so data plus parity always holds an even number of ones. It sits on datapath interfaces that need parity appended to words, or verified on words, with one cycle of latency.

Parameters:
- WIDTH, 3, data width in bits (≥1).
- LANE_W, WIDTH, bits per parity lane. WIDTH must be a multiple of LANE_W. LANES = WIDTH/LANE_W.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, qualifies `in` for this cycle.
- in, input, WIDTH, data word.
- odd_sel, input, 1, 0 = even parity (default use), 1 = odd parity (all parity outputs inverted). Sampled with in_valid.
- frame_start, input, 1, with in_valid: restarts the frame accumulator at this word.
- chk_en, input, 1, with in_valid: compare chk_parity against the computed parity.
- chk_parity, input, LANES, received per-lane parity to check.
- err_clr, input, 1, synchronous clear of err_count and chk_err.
- out_valid, output, 1, registered copy of in_valid.
- data_out, output, WIDTH, registered copy of in.
- parity, output, 1, whole-word parity = ^in XOR odd_sel.
- lane_parity, output, LANES, per-lane parity: bit k = ^in[k*LANE_W +: LANE_W] XOR odd_sel.
- frame_parity, output, 1, running parity over all words since the last frame_start, including the current word.
- chk_err, output, 1, registered mismatch flag for the current word.
- err_count, output, CNT_W, count of mismatching checked words; saturates at all-ones.

Behaviour:
- rst asserted → all outputs and internal state are 0 immediately (async); released synchronously on the next clk edge. rst mid-stream discards the in-flight word. The frame accumulator returns to 0.
- Latency is exactly 1 cycle. On a clk edge with in_valid=1:
  - data_out ← in
  - parity and lane_parity updated
  - out_valid ← 1
- On a clk edge with in_valid=0: out_valid ← 0. data_out, parity, lane_parity, frame_parity and chk_err hold their last values. chk_err is only meaningful while out_valid=1.
- No back-pressure: every valid word is accepted. Back-to-back valid words give back-to-back results.
- Even mode: the parity bit makes the total count of ones even. For WIDTH=3:
  - 000→0, 001→1, 010→1, 011→0
  - 100→1, 101→0, 110→0, 111→1
- Odd mode inverts every parity output.
- Frame accumulator acc (even sense, before odd_sel inversion) on a valid word:
  - frame_start=1 → acc ← ^in
  - otherwise → acc ← acc ^ (^in)
  - frame_parity = acc XOR odd_sel of that word.
- Checker on a valid word with chk_en=1:
  - chk_err ← (chk_parity != lane_parity_next)
  - if mismatch and err_count not saturated, err_count increments.
  - chk_en=0 on a valid word → chk_err ← 0.
- err_clr=1 → err_count ← 0 and chk_err ← 0. err_clr has priority over a simultaneous increment; the word's mismatch is dropped.
- Fully synchronous apart from rst. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-stream with in=3'b111 valid → all outputs 0 asynchronously; after release, first valid word appears 1 cycle later.
- Exhaustive even sweep, WIDTH=3, odd_sel=0: in = 000..111, one per cycle → parity one cycle later = 0,1,1,0,1,0,0,1; out_valid high throughout; data_out equals the delayed input.
- Odd mode: same sweep with odd_sel=1 → parity = 1,0,0,1,0,1,1,0.
- Frame accumulator: frame_start on 001, then 011, then 111 → frame_parity = 1, 1, 0. A new frame_start on 000 → 0.
- Checker: chk_en=1 with in=101, chk_parity=1 → chk_err=1, err_count=1. With chk_parity=0 → chk_err=0, count unchanged. err_clr asserted together with a mismatch → count 0.
- Saturation and gaps: force 2^CNT_W+3 mismatches → err_count stays at all-ones. Insert idle cycles (in_valid=0) → out_valid drops and the outputs hold.
